// File: rtl/song_reader.sv
// song_reader: walks a song ROM and issues each note/duration to note_player with a one-cycle load pulse
module song_reader #(
  parameter int IDX_BITS = 5,
  parameter int SONG_BITS = 2
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          play,
  input  logic [SONG_BITS-1:0]          song,
  input  logic                          note_done,
  output logic [SONG_BITS+IDX_BITS-1:0] rom_addr,
  input  logic [11:0]                   rom_data,
  output logic [5:0]                    note_to_load,
  output logic [5:0]                    duration_to_load,
  output logic                          load_new_note,
  output logic                          song_done
);
  typedef enum logic [2:0] {IDLE, FETCH, LATCH, ISSUE, WAIT_DONE, DONE} state_t;
  state_t state;
  logic [IDX_BITS-1:0] idx;
  logic [SONG_BITS-1:0] current_song;
  assign rom_addr = {current_song, idx};
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx <= '0;
      current_song <= song;
      note_to_load <= '0;
      duration_to_load <= '0;
      load_new_note <= 1'b0;
      song_done <= 1'b0;
    end else if (song != current_song) begin
      state <= IDLE;
      idx <= '0;
      current_song <= song;
      load_new_note <= 1'b0;
      song_done <= 1'b0;
    end else begin
      load_new_note <= 1'b0;
      case (state)
        IDLE: state <= play ? FETCH : IDLE;
        FETCH: state <= LATCH;
        LATCH: begin
          if (rom_data[5:0] == 6'd0) begin
            state <= DONE;
            song_done <= 1'b1;
          end else begin
            note_to_load <= rom_data[11:6];
            duration_to_load <= rom_data[5:0];
            load_new_note <= 1'b1;
            state <= ISSUE;
          end
        end
        ISSUE: state <= WAIT_DONE;
        WAIT_DONE: begin
          if (note_done && &idx) begin
            state <= DONE;
            song_done <= 1'b1;
          end else if (note_done) begin
            idx <= idx + 1'b1;
            state <= IDLE;
          end
        end
        DONE: state <= DONE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_song_reader.sv
// tb_song_reader: table vectors, directed corner sequences and randomized songs checked against a note-list model
module tb_song_reader;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic play = 1'b0;
  logic note_done = 1'b0;
  logic [1:0] song = 2'd0;
  logic [6:0] rom_addr;
  logic [11:0] rom_data = 12'd0;
  logic [5:0] note_to_load, duration_to_load;
  logic load_new_note, song_done;
  logic [11:0] rom [128];
  int passed = 0;
  int total = 0;
  int nloads = 0;
  typedef struct packed {
    logic play;
    logic nd;
    logic ld;
    logic [5:0] nt;
    logic [5:0] du;
    logic [6:0] ad;
    logic dn;
  } vec_t;
  vec_t vt [18];
  always #5 clk = ~clk;
  always @(posedge clk) rom_data <= rom[rom_addr];
  always @(posedge clk) if (load_new_note) nloads++;
  song_reader dut (
    .clk(clk),
    .reset(reset),
    .play(play),
    .song(song),
    .note_done(note_done),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .note_to_load(note_to_load),
    .duration_to_load(duration_to_load),
    .load_new_note(load_new_note),
    .song_done(song_done)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask
  task automatic do_reset(input logic [1:0] s);
    reset = 1'b1;
    song = s;
    note_done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask
  task automatic pulse_done();
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
  endtask
  task automatic wait_load(input int lim, output int n);
    n = 0;
    while (!load_new_note && n < lim) begin
      @(negedge clk);
      n++;
    end
  endtask
  function automatic logic [11:0] rnd_entry();
    return {6'($urandom), 6'($urandom_range(1, 63))};
  endfunction
  function automatic logic [31:0] outs();
    return 32'({load_new_note, note_to_load, duration_to_load, rom_addr, song_done});
  endfunction
  initial begin
    int n, base, s, p, exp_n, g, d, prev;
    for (int i = 0; i < 128; i++) rom[i] = rnd_entry();
    rom[0] = {6'd44, 6'd6};
    rom[1] = {6'd45, 6'd4};
    rom[2] = {6'd9, 6'd0};
    vt[0]  = '{1, 0, 0, 0, 0, 0, 0};
    vt[1]  = '{1, 1, 0, 0, 0, 0, 0};
    vt[2]  = '{1, 0, 0, 0, 0, 0, 0};
    vt[3]  = '{1, 0, 1, 44, 6, 0, 0};
    vt[4]  = '{0, 0, 0, 44, 6, 0, 0};
    vt[5]  = '{1, 1, 0, 44, 6, 0, 0};
    vt[6]  = '{1, 0, 0, 44, 6, 1, 0};
    vt[7]  = '{0, 0, 0, 44, 6, 1, 0};
    vt[8]  = '{1, 0, 0, 44, 6, 1, 0};
    vt[9]  = '{1, 0, 1, 45, 4, 1, 0};
    vt[10] = '{1, 0, 0, 45, 4, 1, 0};
    vt[11] = '{1, 1, 0, 45, 4, 1, 0};
    vt[12] = '{1, 0, 0, 45, 4, 2, 0};
    vt[13] = '{1, 0, 0, 45, 4, 2, 0};
    vt[14] = '{1, 0, 0, 45, 4, 2, 0};
    vt[15] = '{1, 1, 0, 45, 4, 2, 1};
    vt[16] = '{1, 1, 0, 45, 4, 2, 1};
    vt[17] = '{1, 0, 0, 45, 4, 2, 1};
    play = 1'b1;
    do_reset(2'd0);
    for (int i = 0; i < 18; i++) begin
      play = vt[i].play;
      note_done = vt[i].nd;
      chk($sformatf("vec%0d", i), outs(), 32'({vt[i].ld, vt[i].nt, vt[i].du, vt[i].ad, vt[i].dn}));
      @(negedge clk);
    end
    note_done = 1'b0;
    play = 1'b0;
    do_reset(2'd0);
    chk("reset_outs", outs(), 32'd0);
    for (int i = 0; i < 5; i++) begin
      chk("gate_idle", 32'(load_new_note), 32'd0);
      @(negedge clk);
    end
    chk("gate_addr", 32'(rom_addr), 32'd0);
    play = 1'b1;
    wait_load(10, n);
    chk("gate_latency", 32'(n), 32'd3);
    chk("gate_data", 32'({note_to_load, duration_to_load}), 32'(rom[0]));
    @(negedge clk);
    pulse_done();
    wait_load(10, n);
    chk("next_latency", 32'(n), 32'd3);
    chk("next_data", 32'({note_to_load, duration_to_load, rom_addr}), 32'({rom[1], 7'd1}));
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midreset_outs", outs(), 32'd0);
    for (int i = 2; i < 8; i++) rom[i] = rnd_entry();
    do_reset(2'd0);
    for (int k = 0; k < 5; k++) begin
      wait_load(10, n);
      chk("walk_data", 32'({note_to_load, duration_to_load}), 32'(rom[k]));
      @(negedge clk);
      pulse_done();
    end
    wait_load(10, n);
    chk("idx5_addr", 32'(rom_addr), 32'd5);
    @(negedge clk);
    song = 2'd2;
    note_done = 1'b1;
    @(negedge clk);
    note_done = 1'b0;
    chk("chg_outs", 32'({load_new_note, rom_addr, song_done}), 32'({1'b0, 7'd64, 1'b0}));
    wait_load(10, n);
    chk("chg_latency", 32'(n), 32'd3);
    chk("chg_data", 32'({note_to_load, duration_to_load}), 32'(rom[64]));
    for (int i = 32; i < 64; i++) rom[i] = rnd_entry();
    do_reset(2'd1);
    base = nloads;
    for (int k = 0; k < 32; k++) begin
      wait_load(10, n);
      chk("s1_data", 32'({note_to_load, duration_to_load, rom_addr}), 32'({rom[32 + k], 7'(32 + k)}));
      @(negedge clk);
      pulse_done();
    end
    chk("s1_done", 32'({song_done, rom_addr}), 32'({1'b1, 7'd63}));
    for (int i = 0; i < 3; i++) begin
      pulse_done();
      @(negedge clk);
    end
    chk("s1_loads", 32'(nloads - base), 32'd32);
    chk("s1_hold", 32'({song_done, rom_addr}), 32'({1'b1, 7'd63}));
    prev = 1;
    for (int t = 0; t < 25; t++) begin
      s = $urandom_range(0, 3);
      for (int i = 0; i < 32; i++) rom[s * 32 + i] = rnd_entry();
      p = $urandom_range(0, 45);
      if (p < 32) rom[s * 32 + p][5:0] = 6'd0;
      exp_n = 32;
      for (int i = 31; i >= 0; i--) if (rom[s * 32 + i][5:0] == 6'd0) exp_n = i;
      play = 1'b1;
      if (s != prev && $urandom_range(0, 1) == 1) begin
        song = 2'(s);
        @(negedge clk);
      end else do_reset(2'(s));
      prev = s;
      base = nloads;
      for (int k = 0; k < exp_n; k++) begin
        g = $urandom_range(0, 3);
        play = 1'b0;
        repeat (g) @(negedge clk);
        play = 1'b1;
        wait_load(20, n);
        chk("rnd_latency", 32'(n), 32'd3);
        chk("rnd_data", 32'({note_to_load, duration_to_load, rom_addr}), 32'({rom[s * 32 + k], 7'(s * 32 + k)}));
        d = $urandom_range(1, 4);
        repeat (d) @(negedge clk);
        pulse_done();
      end
      repeat (3) @(negedge clk);
      chk("rnd_done", 32'({song_done, rom_addr}), 32'({1'b1, 7'(s * 32 + (exp_n == 32 ? 31 : exp_n))}));
      pulse_done();
      pulse_done();
      repeat (3) @(negedge clk);
      chk("rnd_loads", 32'(nloads - base), 32'(exp_n));
      chk("rnd_hold", 32'(song_done), 32'd1);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
